// File: rtl/mult_operand_loader.sv
// Avalon-MM controlled generator of pseudo-random signed-digit operand pairs.
// An LFSR produces DIGITS digits per entry; each entry is written to A/B RAMs.
module mult_operand_loader #(
    parameter int ID         = 0,
    parameter int RADIX      = 4,
    parameter int DIGITS     = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  avalon_clock,
    input  logic                  resetn,
    input  logic                  read,
    input  logic                  write,
    input  logic [2:0]            address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    output logic                  busy
);

    localparam int DW = $clog2(RADIX) + 1;
    localparam int SW = DW * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [31:0] MASK = 32'h8020_0003;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_GEN   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state;
    logic [2:0]            nxt;
    logic [31:0]           seed_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           written;
    logic [31:0]           lfsr;
    logic [31:0]           lfsr_nx;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH:0]   ent_cnt;
    logic [CW-1:0]         dig_cnt;
    logic [SW-1:0]         sr_a;
    logic [SW-1:0]         sr_b;
    logic [SW-1:0]         sr_a_nx;
    logic [SW-1:0]         sr_b_nx;
    logic [DW-1:0]         digit_a;
    logic [DW-1:0]         digit_b;
    logic [31:0]           rd_mux;
    logic                  done;
    logic                  ctrl_wr;
    logic                  start;
    logic                  abort;
    logic                  dig_last;

    // Digits outside the symmetric range +/-(RADIX-1) collapse to zero
    function automatic logic [DW-1:0] clamp_digit(input logic [DW-1:0] d);
        logic signed [DW-1:0] sd;
        int v;
        sd = d;
        v  = int'(sd);
        if (v > RADIX - 1 || v < -(RADIX - 1))
            return '0;
        return d;
    endfunction

    assign ctrl_wr  = write && (address == 3'd0);
    assign start    = ctrl_wr && writedata[0] && !writedata[1];
    assign abort    = ctrl_wr && writedata[1];
    assign busy     = (state == S_LOAD) || (state == S_GEN) ||
                      (state == S_WRITE);
    assign done     = (state == S_DONE);
    assign dig_last = (dig_cnt == CW'(DIGITS - 1));

    assign lfsr_nx = (lfsr >> 1) ^ (lfsr[0] ? MASK : 32'h0);
    assign digit_a = clamp_digit(lfsr[DW-1:0]);
    assign digit_b = clamp_digit(lfsr[2*DW-1:DW]);
    assign sr_a_nx = SW'({sr_a, digit_a});
    assign sr_b_nx = SW'({sr_b, digit_b});

    // Next-state selection; abort overrides any busy-state transition
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) nxt = S_LOAD;
            S_LOAD:         nxt = S_GEN;
            S_GEN:          if (dig_last) nxt = S_WRITE;
            S_WRITE:        nxt = (ent_cnt == 1) ? S_DONE : S_GEN;
            default:        nxt = S_IDLE;
        endcase
        if (busy && abort)
            nxt = S_IDLE;
    end

    // State register
    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    // Generation datapath and RAM write port; outputs hold between writes
    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn) begin
            lfsr       <= 32'h1;
            addr_cnt   <= '0;
            ent_cnt    <= '0;
            dig_cnt    <= '0;
            sr_a       <= '0;
            sr_b       <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data_a <= '0;
            ram_data_b <= '0;
        end else begin
            ram_we <= (nxt == S_WRITE);
            case (state)
                S_LOAD: begin
                    lfsr     <= (seed_q == 32'h0) ? 32'h1 : seed_q;
                    addr_cnt <= base_q;
                    ent_cnt  <= (count_q == '0) ?
                                {1'b1, {ADDR_WIDTH{1'b0}}} : count_q;
                    dig_cnt  <= '0;
                end
                S_GEN: begin
                    lfsr    <= lfsr_nx;
                    sr_a    <= sr_a_nx;
                    sr_b    <= sr_b_nx;
                    dig_cnt <= dig_last ? '0 : dig_cnt + 1'b1;
                    if (nxt == S_WRITE) begin
                        ram_addr   <= addr_cnt;
                        ram_data_a <= DATA_WIDTH'(sr_a_nx);
                        ram_data_b <= DATA_WIDTH'(sr_b_nx);
                    end
                end
                S_WRITE: begin
                    addr_cnt <= addr_cnt + 1'b1;
                    ent_cnt  <= ent_cnt - 1'b1;
                    dig_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Configuration registers are frozen while a run is in progress
    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn) begin
            seed_q  <= '0;
            count_q <= '0;
            base_q  <= '0;
        end else if (write && !busy) begin
            case (address)
                3'd2:    seed_q  <= writedata;
                3'd3:    count_q <= writedata[ADDR_WIDTH:0];
                3'd4:    base_q  <= writedata[ADDR_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Entries written since the last accepted start
    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn)
            written <= '0;
        else if (start && !busy)
            written <= '0;
        else if (state == S_WRITE)
            written <= written + 1'b1;
    end

    // Register read mux
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd1:    rd_mux = {30'h0, done, busy};
            3'd2:    rd_mux = seed_q;
            3'd3:    rd_mux = 32'(count_q);
            3'd4:    rd_mux = 32'(base_q);
            3'd5:    rd_mux = written;
            3'd6:    rd_mux = 32'(ID);
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, updated on each sampled read
    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn)
            readdata <= '0;
        else if (read)
            readdata <= rd_mux;
    end

endmodule

// File: tb/tb_mult_operand_loader.sv
// Scoreboard bench for mult_operand_loader.
// Expected RAM writes and register reads are queued and checked by a monitor.
module tb_mult_operand_loader;

    logic         clk;
    logic         resetn;
    logic         read;
    logic         write;
    logic [2:0]   address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         ram_we;
    logic [7:0]   ram_addr;
    logic [255:0] ram_data_a;
    logic [255:0] ram_data_b;
    logic         busy;

    typedef struct {
        logic [7:0]   addr;
        logic [255:0] a;
        logic [255:0] b;
        int           cyc;
        bit           hand;
    } wexp_t;

    wexp_t       wr_q[$];
    logic [31:0] rd_q[$];
    string       rd_n[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int sc    = 0;
    logic rd_seen = 1'b0;

    mult_operand_loader #(
        .ID(165)
    ) dut (
        .avalon_clock(clk),
        .resetn(resetn),
        .read(read),
        .write(write),
        .address(address),
        .writedata(writedata),
        .readdata(readdata),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_data_a(ram_data_a),
        .ram_data_b(ram_data_b),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_seen <= read;
    end

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference LFSR digit generator for one entry
    task automatic model_entry(inout logic [31:0] s,
                               output logic [255:0] a,
                               output logic [255:0] b);
        logic [2:0] da;
        logic [2:0] db;
        a = '0;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            da = s[2:0];
            db = s[5:3];
            if (da == 3'b100) da = 3'b000;
            if (db == 3'b100) db = 3'b000;
            a = (a << 3) | 256'(da);
            b = (b << 3) | 256'(db);
            s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
        end
    endtask

    // Monitor: compares every read response and every RAM write
    always @(negedge clk) begin : mon
        wexp_t e;
        logic [31:0] r;
        string n;
        bit bad;
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                r = rd_q.pop_front();
                n = rd_n.pop_front();
                chk(n, 256'(readdata), 256'(r));
            end
        end
        if (ram_we) begin
            if (wr_q.size() == 0) begin
                chk("we_unexpected", 256'(ram_addr), 256'hDEAD);
            end else begin
                e = wr_q.pop_front();
                chk("we_cycle", 256'(cyc), 256'(e.cyc));
                chk("we_addr", 256'(ram_addr), 256'(e.addr));
                chk("data_a", ram_data_a, e.a);
                chk("data_b", ram_data_b, e.b);
                bad = 1'b0;
                for (int k = 0; k < 32; k++) begin
                    if (ram_data_a[3*k +: 3] == 3'b100) bad = 1'b1;
                    if (ram_data_b[3*k +: 3] == 3'b100) bad = 1'b1;
                end
                chk("digit_range", 256'(bad), 256'(0));
                if (e.hand) begin
                    chk("hand_a_top", 256'(ram_data_a[95:84]), 256'(12'h2D1));
                    chk("hand_b_top", 256'(ram_data_b[95:84]), 256'(12'h000));
                end
            end
        end
    end

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, input logic [31:0] exp,
                          input string name);
        rd_q.push_back(exp);
        rd_n.push_back(name);
        address = a;
        read    = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input logic [31:0] seed, input int count,
                             input logic [7:0] base, input int npush,
                             input bit hand);
        logic [31:0] s;
        wexp_t e;
        bus_wr(3'd2, seed);
        bus_wr(3'd3, 32'(count));
        bus_wr(3'd4, 32'(base));
        sc = cyc;
        s  = (seed == 32'h0) ? 32'h1 : seed;
        for (int i = 0; i < npush; i++) begin
            model_entry(s, e.a, e.b);
            e.addr = base + 8'(i);
            e.cyc  = sc + 34 + 33 * i;
            e.hand = hand;
            wr_q.push_back(e);
        end
        bus_wr(3'd0, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn    = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        address   = 3'd0;
        writedata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 256'(ram_we), 0);
        chk("rst_busy", 256'(busy), 0);
        chk("rst_readdata", 256'(readdata), 0);
        chk("rst_addr", 256'(ram_addr), 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        bus_rd(3'd1, 32'h0, "rst_status");
        bus_rd(3'd5, 32'h0, "rst_written");
        bus_rd(3'd6, 32'd165, "rst_id");
        bus_rd(3'd7, 32'h0, "reg7_zero");

        // Single entry, seed 1
        start_run(32'h1, 1, 8'h10, 1, 1'b1);
        chk("busy_load", 256'(busy), 1);
        wait_until(sc + 34);
        chk("busy_write", 256'(busy), 1);
        wait_until(sc + 35);
        chk("busy_done", 256'(busy), 0);
        bus_rd(3'd1, 32'h2, "status_done");
        bus_rd(3'd5, 32'h1, "written_1");
        chk("drain_1", 256'(wr_q.size()), 0);

        // Seed 0 behaves as seed 1
        start_run(32'h0, 1, 8'h20, 1, 1'b1);
        wait_until(sc + 38);
        bus_rd(3'd1, 32'h2, "status_seed0");
        chk("drain_seed0", 256'(wr_q.size()), 0);

        // Address wrap; config writes and restart while busy are ignored
        start_run(32'hACE1, 4, 8'hFE, 4, 1'b0);
        wait_until(sc + 20);
        bus_wr(3'd2, 32'h5555);
        wait_until(sc + 40);
        bus_wr(3'd0, 32'h1);
        wait_until(sc + 134);
        chk("busy_wrap_done", 256'(busy), 0);
        bus_rd(3'd2, 32'hACE1, "seed_held");
        bus_rd(3'd5, 32'h4, "written_4");
        bus_rd(3'd1, 32'h2, "status_wrap");
        chk("drain_wrap", 256'(wr_q.size()), 0);

        // COUNT=0 means a full 256-entry sweep
        start_run(32'h1234_5678, 0, 8'h80, 256, 1'b0);
        wait_until(sc + 1 + 256 * 33 + 3);
        bus_rd(3'd5, 32'd256, "written_256");
        chk("drain_256", 256'(wr_q.size()), 0);

        // Abort during the third entry's generation
        start_run(32'hBEEF, 5, 8'h30, 2, 1'b0);
        wait_until(sc + 75);
        chk("busy_pre_abort", 256'(busy), 1);
        bus_wr(3'd0, 32'h2);
        chk("busy_abort", 256'(busy), 0);
        bus_rd(3'd1, 32'h0, "status_abort");
        bus_rd(3'd5, 32'h2, "written_abort");
        repeat (60) @(posedge clk);
        #1;
        chk("drain_abort", 256'(wr_q.size()), 0);

        // Reset mid-generation
        start_run(32'h77, 3, 8'h00, 0, 1'b0);
        wait_until(sc + 10);
        resetn = 1'b0;
        #1;
        chk("midrst_we", 256'(ram_we), 0);
        chk("midrst_busy", 256'(busy), 0);
        chk("midrst_addr", 256'(ram_addr), 0);
        chk("midrst_data_a", ram_data_a, 0);
        chk("midrst_data_b", ram_data_b, 0);
        chk("midrst_readdata", 256'(readdata), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        chk("postrst_busy", 256'(busy), 0);
        bus_rd(3'd2, 32'h0, "postrst_seed");
        bus_rd(3'd3, 32'h0, "postrst_count");
        bus_rd(3'd4, 32'h0, "postrst_base");
        bus_rd(3'd5, 32'h0, "postrst_written");

        // Normal run after reset
        start_run(32'h1357, 1, 8'h42, 1, 1'b0);
        wait_until(sc + 38);
        bus_rd(3'd5, 32'h1, "written_after");
        bus_rd(3'd1, 32'h2, "status_after");
        repeat (3) @(posedge clk);
        #1;
        chk("drain_final", 256'(wr_q.size()), 0);
        chk("rd_drain", 256'(rd_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
